mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the load/store handshake driven by the memory FSM.
- Samples the request when memEN rises: RW, the address from the MAR and the write data from the MDR.
- Inserts a parameterised number of wait states, then performs the access and raises MFC (memory function complete).
- Holds MFC until the initiator drops memEN. Sits between the MAR/MDR datapath and the controller.

Parameters:
- DATA_W, 16, data word width (matches MDR).
- ADDR_W, 8, address port width (matches MAR).
- DEPTH, 256, number of words; power of two, at most 2**ADDR_W.
- WAIT_CYCLES, 2, wait states between request capture and MFC; legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- memEN  in  1  request strobe from the controller; held high until MFC is seen, and for reads one cycle beyond.
- RW  in  1  1 = read (load), 0 = write (store).
- addr  in  ADDR_W  word address from the MAR.
- dataIn  in  DATA_W  write data from the MDR.
- dataOut  out  DATA_W  read data to the MDR; registered.
- MFC  out  1  access complete; registered.
- busy  out  1  high in WAIT and ACK.
- memErr  out  1  address-range error; see Optional Feature.

Behaviour:
- Reset: state IDLE; MFC=0, busy=0, memErr=0, dataOut=0; wait counter=0; any pending write is discarded. The memory array is not cleared (contents undefined at power-up).
- States and transitions:
  - IDLE: if memEN=1 at an edge, capture RW, addr and dataIn into registers, load the counter with WAIT_CYCLES, and go to WAIT. Otherwise stay.
  - WAIT: if memEN=0, abort to IDLE with no access and no MFC. Else if counter=0, perform the access and go to ACK. Else decrement the counter.
  - ACK: MFC=1. Stay while memEN=1. On memEN=0, go to IDLE and clear MFC on that edge.
- Access on the WAIT->ACK edge:
  - Write: mem[idx] <= captured data.
  - Read: dataOut <= mem[idx].
  - idx = captured addr[log2(DEPTH)-1:0].
- Latency: memEN first sampled high at edge N gives MFC high after edge N+1+WAIT_CYCLES. With WAIT_CYCLES=0, MFC is high after edge N+1.
- Captured values are used for the whole transaction. Changes on addr, dataIn or RW after capture are ignored.
- dataOut holds its value after the read until the next read completes. Writes never change dataOut.
- busy = (state != IDLE). It is combinational from the state register.
- Back-to-back: after ACK->IDLE, memEN must be sampled low for at least one edge before a new request. A new request is accepted only on an IDLE edge with memEN=1, so a request held high across the ACK->IDLE edge is not re-accepted until memEN drops and rises again.
- Reset mid-WAIT or mid-ACK: immediate return to IDLE. An uncommitted write is not performed; a write already committed in ACK stays.
- RW=1 and RW=0 share one path; no simultaneous read and write.

Optional Feature:
- Macro MEM_ADDR_CHECK_EN.
- When defined, a captured addr >= DEPTH is out of range:
  - Write is suppressed.
  - dataOut is loaded with 0.
  - memErr is set on the same edge as MFC and cleared with MFC.
  - The handshake timing is unchanged.
- When undefined, memErr is tied 0 and the address is truncated to its low log2(DEPTH) bits (wraps). Only meaningful when DEPTH < 2**ADDR_W.

Test Plan:
- Write then read, WAIT_CYCLES=2: memEN=1, RW=0, addr=0x05, dataIn=0xBEEF; MFC rises 3 edges after capture; drop memEN; then memEN=1, RW=1, addr=0x05 -> MFC after 3 edges with dataOut=0xBEEF, held until memEN falls.
- WAIT_CYCLES=0: read addr=0x00 after writing 0x1234 -> MFC one edge after capture, dataOut=0x1234.
- Abort: memEN=1, RW=0, addr=0x10, data=0xAAAA, memEN dropped in WAIT -> MFC never asserts; a later read of 0x10 returns the prior value.
- Capture isolation: change addr to 0x06 and dataIn to 0x5555 during WAIT of a write to 0x05 with 0x7777 -> mem[0x05]=0x7777, mem[0x06] unchanged.
- Reset mid-WAIT of a write -> MFC=0, busy=0, dataOut=0 at once; the write does not occur.
- MEM_ADDR_CHECK_EN with DEPTH=128: write 0x9999 to addr=0x85 -> MFC=1 with memErr=1, mem[0x05] unchanged. Read 0x85 -> dataOut=0x0000, memErr=1. With the macro undefined, the same write lands in mem[0x05].

Source files
------------

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the memEN/MFC load/store handshake.
//   A request is captured (RW, addr, dataIn) on the first edge memEN is seen
//   high in IDLE. The block then counts WAIT_CYCLES wait states, performs
//   the access and raises MFC. MFC is held until memEN drops.
//
//   Optional build macro: MEM_ADDR_CHECK_EN
//     defined   : a captured addr >= DEPTH suppresses the write, returns 0 on
//                 a read and raises memErr alongside MFC.
//     undefined : memErr is tied low and the address wraps modulo DEPTH.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   memEN    in   request strobe from the controller
//   RW       in   1 = read (load), 0 = write (store)
//   addr     in   [ADDR_W-1:0] word address (MAR)
//   dataIn   in   [DATA_W-1:0] write data (MDR)
//   dataOut  out  [DATA_W-1:0] registered read data
//   MFC      out  registered access-complete flag
//   busy     out  high while a transaction is in flight (WAIT or ACK)
//   memErr   out  registered address-range error flag
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memEN,
  input  logic              RW,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              MFC,
  output logic              busy,
  output logic              memErr
);

  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  // Catch illegal configurations at elaboration time.
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_responder: WAIT_CYCLES must be in 0..15");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
    $error("mem_responder: DEPTH must be a power of two in 2..2**ADDR_W");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic              capture;
  logic              access;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  logic [DATA_W-1:0] mem [DEPTH];

  assign idx  = addr_q[IDX_W-1:0];
  assign busy = (state_q != S_IDLE);

`ifdef MEM_ADDR_CHECK_EN
  // Compare one bit wider so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  assign in_range = ({1'b0, addr_q} < DEPTH_EXT);
`else
  // Upper address bits (if any) are simply dropped: the address wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_q;
  assign in_range         = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (memEN) begin
          capture = 1'b1;
          cnt_d   = WAIT_LD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!memEN) begin
          // Initiator gave up: no access, no MFC.
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        if (!memEN) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      dataOut <= '0;
      MFC     <= 1'b0;
      memErr  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        rw_q   <= RW;
        addr_q <= addr;
        data_q <= dataIn;
      end
      // MFC/memErr follow the state they will describe, so they rise on the
      // WAIT->ACK edge and clear on the ACK->IDLE edge.
      MFC    <= (state_d == S_ACK);
      memErr <= (state_d == S_ACK) && !in_range;
      if (access && rw_q) begin
        dataOut <= in_range ? mem[idx] : '0;
      end
    end
  end

  // Storage array: deliberately not reset. access is decoded from the
  // asynchronously reset state, so no write can slip through under reset.
  always_ff @(posedge clk) begin
    if (access && !rw_q && in_range) begin
      mem[idx] <= data_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//   Two responders: u0 (DEPTH=128, WAIT_CYCLES=2) and u1 (DEPTH=256,
//   WAIT_CYCLES=0). A table of transactions is run through a handshake task
//   with a scoreboard queue; abort and reset-mid-WAIT are hand-written.
// ---------------------------------------------------------------------------
module tb_mem_responder;

`ifdef MEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        memEN   [2];
  logic        RW      [2];
  logic [7:0]  addr    [2];
  logic [15:0] dataIn  [2];
  logic [15:0] dataOut [2];
  logic        MFC     [2];
  logic        busy    [2];
  logic        memErr  [2];

  int          wc      [2] = '{2, 0};
  logic [15:0] last_rd [2];

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          d;
    bit          rw;
    logic [7:0]  a;
    logic [15:0] din;
    logic [15:0] exp_d;
    bit          exp_err;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .memEN(memEN[0]), .RW(RW[0]), .addr(addr[0]),
    .dataIn(dataIn[0]), .dataOut(dataOut[0]), .MFC(MFC[0]), .busy(busy[0]),
    .memErr(memErr[0])
  );

  mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .memEN(memEN[1]), .RW(RW[1]), .addr(addr[1]),
    .dataIn(dataIn[1]), .dataOut(dataOut[1]), .MFC(MFC[1]), .busy(busy[1]),
    .memErr(memErr[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full handshake. After the capture edge the request inputs are
  // scrambled, so every transaction also checks capture isolation.
  task automatic xact(input int d, input bit rw, input logic [7:0] a,
                      input logic [15:0] din, input logic [15:0] exp_d,
                      input bit exp_err);
    exp_t e;
    int   lat;
    @(negedge clk);
    memEN[d] = 1'b1; RW[d] = rw; addr[d] = a; dataIn[d] = din;
    e.data = rw ? exp_d : last_rd[d];
    e.err  = exp_err;
    sb.push_back(e);
    @(posedge clk); #1;
    chk($sformatf("u%0d busy after capture a=%0h", d, a), busy[d], 1);
    addr[d] = a + 8'd1; dataIn[d] = 16'h5555; RW[d] = ~rw;
    lat = 0;
    while (!MFC[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("u%0d MFC latency a=%0h", d, a), lat, wc[d] + 1);
    e = sb.pop_front();
    chk($sformatf("u%0d dataOut a=%0h rw=%0d", d, a, rw), dataOut[d], e.data);
    chk($sformatf("u%0d memErr a=%0h", d, a), memErr[d], e.err);
    if (rw) last_rd[d] = e.data;
    @(posedge clk); #1;
    chk($sformatf("u%0d MFC held a=%0h", d, a), MFC[d], 1);
    @(negedge clk);
    memEN[d] = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("u%0d MFC cleared a=%0h", d, a), MFC[d], 0);
    chk($sformatf("u%0d memErr cleared a=%0h", d, a), memErr[d], 0);
    chk($sformatf("u%0d busy idle a=%0h", d, a), busy[d], 0);
    chk($sformatf("u%0d dataOut kept a=%0h", d, a), dataOut[d], last_rd[d]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table: {dut, rw, addr, din, expected read data, expected memErr}
    tbl.push_back('{0, 0, 8'h05, 16'hBEEF, 16'h0000, 0});
    tbl.push_back('{0, 1, 8'h05, 16'h0000, 16'hBEEF, 0});
    tbl.push_back('{0, 0, 8'h06, 16'h6666, 16'h0000, 0});
    tbl.push_back('{0, 0, 8'h05, 16'h7777, 16'h0000, 0});
    tbl.push_back('{0, 1, 8'h05, 16'h0000, 16'h7777, 0});
    tbl.push_back('{0, 1, 8'h06, 16'h0000, 16'h6666, 0});
    tbl.push_back('{0, 0, 8'h10, 16'h1111, 16'h0000, 0});
    tbl.push_back('{0, 0, 8'h7F, 16'h0F0F, 16'h0000, 0});
    tbl.push_back('{0, 1, 8'h7F, 16'h0000, 16'h0F0F, 0});
    tbl.push_back('{0, 0, 8'h85, 16'h9999, 16'h0000, CHK});
    tbl.push_back('{0, 1, 8'h05, 16'h0000, CHK ? 16'h7777 : 16'h9999, 0});
    tbl.push_back('{0, 1, 8'h85, 16'h0000, CHK ? 16'h0000 : 16'h9999, CHK});
    tbl.push_back('{1, 0, 8'h00, 16'h1234, 16'h0000, 0});
    tbl.push_back('{1, 1, 8'h00, 16'h0000, 16'h1234, 0});
    tbl.push_back('{1, 0, 8'hFF, 16'hABCD, 16'h0000, 0});
    tbl.push_back('{1, 1, 8'hFF, 16'h0000, 16'hABCD, 0});
    tbl.push_back('{1, 1, 8'h00, 16'h0000, 16'h1234, 0});

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      memEN[d] = 1'b0; RW[d] = 1'b0; addr[d] = '0; dataIn[d] = '0;
      last_rd[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("u%0d reset MFC", d), MFC[d], 0);
      chk($sformatf("u%0d reset busy", d), busy[d], 0);
      chk($sformatf("u%0d reset memErr", d), memErr[d], 0);
      chk($sformatf("u%0d reset dataOut", d), dataOut[d], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i])
      xact(tbl[i].d, tbl[i].rw, tbl[i].a, tbl[i].din, tbl[i].exp_d, tbl[i].exp_err);

    // Abort: memEN dropped during WAIT, no access and no MFC.
    @(negedge clk);
    memEN[0] = 1'b1; RW[0] = 1'b0; addr[0] = 8'h10; dataIn[0] = 16'hAAAA;
    @(posedge clk); #1;
    chk("abort busy in WAIT", busy[0], 1);
    @(negedge clk);
    memEN[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort MFC low cyc%0d", k), MFC[0], 0);
    end
    chk("abort busy idle", busy[0], 0);
    xact(0, 1, 8'h10, 16'h0000, 16'h1111, 0);

    // Reset in the middle of a write's WAIT: write must not land.
    xact(0, 0, 8'h20, 16'h2222, 16'h0000, 0);
    xact(0, 1, 8'h20, 16'h0000, 16'h2222, 0);
    @(negedge clk);
    memEN[0] = 1'b1; RW[0] = 1'b0; addr[0] = 8'h20; dataIn[0] = 16'hDEAD;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst mid-WAIT MFC", MFC[0], 0);
    chk("rst mid-WAIT busy", busy[0], 0);
    chk("rst mid-WAIT dataOut", dataOut[0], 0);
    chk("rst u1 dataOut", dataOut[1], 0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    memEN[0] = 1'b0;
    rst = 1'b0;
    xact(0, 1, 8'h20, 16'h0000, 16'h2222, 0);
    xact(1, 1, 8'hFF, 16'h0000, 16'hABCD, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
